baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//  Parametrised fractional baud generator for the UART RX/TX paths. Produces a
//  one-clk oversample enable (ovs_tick), a 1x bit enable (bit_tick) and a
//  mid-bit sample enable (mid_tick). The divisor (integer + fraction) can be
//  changed at run time and is applied glitch-free at a period boundary.
//  rx_resync lets the receiver phase-align the generator to a start-bit edge.
//  Ticks are enables, never clocks.
// PARAMETERS
//  DIV_W   16  width of integer divisor div_int (clk cycles per oversample tick)
//  FRAC_W   4  width of fractional divisor div_frac (units of 1/2^FRAC_W cycle)
//  OVS     16  oversample ratio, ovs_ticks per bit; power of 2, >= 4
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  reset        in   1          synchronous, active-low (0 = reset)
//  en           in   1          1 = run; 0 = freeze counters, no ticks
//  div_int      in   DIV_W      integer part of the oversample period
//  div_frac     in   FRAC_W     fractional part of the oversample period
//  div_load     in   1          1-clk pulse: capture div_int/div_frac
//  rx_resync    in   1          1-clk pulse: restart period and phase at 0
//  ovs_tick     out  1          1-clk pulse per oversample period
//  bit_tick     out  1          1-clk pulse per bit (every OVS ovs_ticks)
//  mid_tick     out  1          1-clk pulse at the mid-bit ovs_tick
//  ovs_phase    out  log2(OVS)  oversample index within the current bit
//  div_pending  out  1          captured divisor not yet active
// BEHAVIOUR
//  - Reset (reset=0 at posedge): cnt=0, acc=0, ovs_phase=0, all tick outputs 0,
//    div_pending=0, active divisor = {2, 0}. Reset overrides all other inputs.
//  - Period: len = max(div_int_act, 2) + carry. Each enabled clk: if cnt==len-1
//    then cnt<=0 and ovs_tick<=1 (registered), else cnt<=cnt+1 and ovs_tick<=0.
//    The first ovs_tick is visible len clks after the first enabled edge.
//  - Fraction: at each boundary {carry, acc} <= acc + div_frac_act (FRAC_W+1
//    bits). carry lengthens the next period by 1 clk. The long-run mean period
//    is div_int + div_frac/2^FRAC_W.
//  - Phase: ovs_phase <= (ovs_phase+1) mod OVS, with ovs_tick. bit_tick=1 with
//    the ovs_tick whose new phase is 0. mid_tick=1 with the ovs_tick whose new
//    phase is OVS/2. All three ticks are pulses in the same cycle.
//  - Divisor update: div_load sets the shadow register and div_pending=1. The
//    shadow becomes active at the next boundary, which is cnt wrap,
//    rx_resync, or any clk with en=0; div_pending then clears. div_load on a
//    boundary cycle applies the input value at that boundary. A second
//    div_load before apply overwrites the shadow. acc is not cleared on an
//    update.
//  - en=0: cnt/acc/phase hold and all ticks are 0. Operation resumes from the
//    held cnt when en=1.
//  - rx_resync (gated by en): cnt<=0, acc<=0, ovs_phase<=0. Ticks are
//    suppressed that cycle even if cnt==len-1 (resync wins). The next
//    ovs_tick follows len clks later.
//  - div_int of 0 or 1 is treated as 2; ovs_tick is never continuous.
// TESTING
//  1 div_int=4, frac=0, en=1: ovs_tick every 4 clks; bit_tick every 64 clks;
//    mid_tick 32 clks after each bit_tick.
//  2 div_int=4, frac=8: ovs_tick intervals 4,4,5,4,5,...; 16 ticks in 72 clks.
//  3 div_load div_int=10 mid-period: current period completes at the old length
//    and div_pending=1 until that boundary; following intervals are 10.
//  4 rx_resync asserted when cnt==len-1: no ovs_tick that cycle; ovs_phase=0;
//    next ovs_tick exactly len clks later.
//  5 en=0 for 7 clks mid-period: no ticks, cnt held; on resume the remaining
//    period completes with interval +7 vs nominal.
//  6 reset=0 mid-operation with div_int=9 active: all outputs 0 next cycle;
//    after release the period is 2 clks (default) until div_load.

Source files
------------

// File: rtl/baud_gen_frac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : baud_gen_frac                                              |
// | Description : Fractional baud generator producing oversample, bit and    |
// |               mid-bit enables with run-time divisor update and resync.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [DIV_W-1:0]         div_int,
  input  logic [FRAC_W-1:0]        div_frac,
  input  logic                     div_load,
  input  logic                     rx_resync,
  output logic                     ovs_tick,
  output logic                     bit_tick,
  output logic                     mid_tick,
  output logic [$clog2(OVS)-1:0]   ovs_phase,
  output logic                     div_pending
);

  localparam int                  c_PH_W   = $clog2(OVS);
  localparam int                  c_CW     = DIV_W + 1;
  localparam logic [c_PH_W-1:0]   c_PH_MID = c_PH_W'(OVS / 2);
  localparam logic [DIV_W-1:0]    c_MIN_DIV = DIV_W'(2);

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [DIV_W-1:0]  r_int_act;
  logic [FRAC_W-1:0] r_frac_act;
  logic [DIV_W-1:0]  r_int_shd;
  logic [FRAC_W-1:0] r_frac_shd;

  logic [DIV_W-1:0]  w_int_eff;
  logic [c_CW-1:0]   w_len_m1;
  logic              w_resync;
  logic              w_wrap;
  logic              w_boundary;
  logic [DIV_W-1:0]  w_int_next;
  logic [FRAC_W-1:0] w_frac_next;
  logic [FRAC_W:0]   w_acc_sum;
  logic [c_PH_W-1:0] w_phase_inc;

  always_comb begin
    w_int_eff   = (r_int_act < c_MIN_DIV) ? c_MIN_DIV : r_int_act;
    w_len_m1    = {1'b0, w_int_eff} + {{DIV_W{1'b0}}, r_carry} - c_CW'(1);
    w_resync    = en & rx_resync;
    // >= keeps the counter from running away if a shorter divisor lands mid-period
    w_wrap      = en & ({1'b0, r_cnt} >= w_len_m1);
    w_boundary  = ~en | w_resync | w_wrap;
    w_int_next  = r_int_act;
    w_frac_next = r_frac_act;
    if (div_load) begin
      w_int_next  = div_int;
      w_frac_next = div_frac;
    end else if (div_pending) begin
      w_int_next  = r_int_shd;
      w_frac_next = r_frac_shd;
    end
    w_acc_sum   = {1'b0, r_acc} + {1'b0, w_frac_next};
    w_phase_inc = ovs_phase + c_PH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_int_act   <= c_MIN_DIV;
      r_frac_act  <= '0;
      r_int_shd   <= c_MIN_DIV;
      r_frac_shd  <= '0;
      ovs_tick    <= 1'b0;
      bit_tick    <= 1'b0;
      mid_tick    <= 1'b0;
      ovs_phase   <= '0;
      div_pending <= 1'b0;
    end else begin
      ovs_tick <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;

      if (div_load) begin
        r_int_shd  <= div_int;
        r_frac_shd <= div_frac;
      end
      if (w_boundary) begin
        r_int_act   <= w_int_next;
        r_frac_act  <= w_frac_next;
        div_pending <= 1'b0;
      end else if (div_load) begin
        div_pending <= 1'b1;
      end

      if (w_resync) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_carry   <= 1'b0;
        ovs_phase <= '0;
      end else if (w_wrap) begin
        r_cnt              <= '0;
        {r_carry, r_acc}   <= w_acc_sum;
        ovs_tick           <= 1'b1;
        ovs_phase          <= w_phase_inc;
        bit_tick           <= (w_phase_inc == '0);
        mid_tick           <= (w_phase_inc == c_PH_MID);
      end else if (en) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
